// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types and constants: instruction width, bubble word, fetch FSM encoding.
package instr_fetch_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

    // Encoding is {skid_v, req_v}; 2'b11 is unreachable by construction.
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_HELD = 2'b10
    } fetch_state_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0
    } opcode_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction+pc holding buffer; occupancy is tracked by the fetch FSM.
module fetch_skid_buf
    import instr_fetch_pkg::*;
#(
    parameter int unsigned PC_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc,
    output logic [INSTR_W-1:0] skid_instr,
    output logic [PC_W-1:0]    skid_pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_instr <= NOP_WORD;
            skid_pc    <= '0;
        end else if (load) begin
            skid_instr <= load_instr;
            skid_pc    <= load_pc;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, one outstanding synchronous imem read, IF/ID register with
// stall hold, redirect flush and a one-entry skid buffer so no word is lost across stalls.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned       PC_W      = 12,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_WORD
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    fpc_q, fpc_d;
    logic [PC_W-1:0]    req_pc_q, req_pc_d;
    logic [INSTR_W-1:0] instr_d;
    logic [PC_W-1:0]    pc_d;
    logic               valid_d;
    logic               skid_load;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;
    logic               req_v;
    logic               skid_v;

    assign req_v     = (state_q == FETCH_REQ);
    assign skid_v    = (state_q == FETCH_HELD);
    assign imem_addr = fpc_q;

    fetch_skid_buf #(
        .PC_W (PC_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .load_instr (imem_rdata),
        .load_pc    (req_pc_q),
        .skid_instr (skid_instr),
        .skid_pc    (skid_pc)
    );

    // State, PC and IF/ID registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH_IDLE;
            fpc_q       <= RESET_PC;
            req_pc_q    <= '0;
            instruction <= NOP_INSTR;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            req_pc_q    <= req_pc_d;
            instruction <= instr_d;
            instr_pc    <= pc_d;
            instr_valid <= valid_d;
        end
    end

    // Next state: redirect beats stall beats advance.
    always_comb begin
        state_d   = state_q;
        fpc_d     = fpc_q;
        req_pc_d  = req_pc_q;
        instr_d   = instruction;
        pc_d      = instr_pc;
        valid_d   = instr_valid;
        skid_load = 1'b0;

        if (redirect) begin
            instr_d = NOP_INSTR;
            pc_d    = '0;
            valid_d = 1'b0;
            fpc_d   = redirect_pc;
            state_d = FETCH_IDLE;
        end else if (stall) begin
            // The word returning this cycle is parked so release needs no refetch.
            skid_load = req_v;
            state_d   = (req_v || skid_v) ? FETCH_HELD : FETCH_IDLE;
        end else begin
            if (skid_v) begin
                instr_d = skid_instr;
                pc_d    = skid_pc;
                valid_d = 1'b1;
            end else if (req_v) begin
                instr_d = imem_rdata;
                pc_d    = req_pc_q;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                pc_d    = req_pc_q;
                valid_d = 1'b0;
            end
            req_pc_d = fpc_q;
            fpc_d    = fpc_q + PC_W'(1);
            state_d  = FETCH_REQ;
        end
    end

endmodule
